// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic tile front end: FSM state encoding,
// default array geometry and the row-major flat-bus index helper.
package systolic_pkg;

  localparam int unsigned DefArraySize   = 8;
  localparam int unsigned DefDataWidth   = 16;
  localparam int unsigned DefWeightWidth = 8;
  localparam int unsigned DefAccumWidth  = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StStart,
    StWait,
    StDrain
  } state_e;

  // Element [i][j] of an n x n matrix sits at flat position i*n+j.
  function automatic int unsigned idx(input int unsigned i, input int unsigned j,
                                      input int unsigned n = DefArraySize);
    return i * n + j;
  endfunction

endpackage

// File: rtl/tile_rc_counter.sv
// Row-major row/column walker with programmable limits; flags the end of each row and the
// final element. Wraps back to [0][0] after the last step.
module tile_rc_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         step_i,
  input  logic [W-1:0] row_lim_i,
  input  logic [W-1:0] col_lim_i,
  output logic [W-1:0] row_o,
  output logic [W-1:0] col_o,
  output logic         wrap_o,
  output logic         last_o
);

  logic [W-1:0] row_q, row_d, col_q, col_d;

  assign wrap_o = (col_q == col_lim_i - W'(1));
  assign last_o = wrap_o && (row_q == row_lim_i - W'(1));
  assign row_o  = row_q;
  assign col_o  = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (step_i) begin
      if (wrap_o) begin
        col_d = '0;
        row_d = last_o ? '0 : row_q + W'(1);
      end else begin
        col_d = col_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/systolic_tile_controller.sv
// Tile front end for systolic_array_top: loads zero-padded A/B operands, pulses start, then
// streams the valid MxN result region row-major. Define TILE_TIMEOUT_EN for the WAIT watchdog.
module systolic_tile_controller
  import systolic_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE     = DefArraySize,
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned WEIGHT_WIDTH   = DefWeightWidth,
  parameter int unsigned ACCUM_WIDTH    = DefAccumWidth,
  parameter int unsigned DW             = $clog2(ARRAY_SIZE) + 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           cfg_valid,
  output logic                                           cfg_ready,
  input  logic [DW-1:0]                                  cfg_rows,
  input  logic [DW-1:0]                                  cfg_cols,
  input  logic [DW-1:0]                                  cfg_inner,
  input  logic                                           a_valid,
  output logic                                           a_ready,
  input  logic [DATA_WIDTH-1:0]                          a_data,
  input  logic                                           b_valid,
  output logic                                           b_ready,
  input  logic [WEIGHT_WIDTH-1:0]                        b_data,
  output logic                                           r_valid,
  input  logic                                           r_ready,
  output logic [ACCUM_WIDTH-1:0]                         r_data,
  output logic                                           r_last,
  output logic                                           sa_start,
  output logic [DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]    sa_matrix_a_flat,
  output logic [WEIGHT_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]  sa_matrix_b_flat,
  input  logic [ACCUM_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]   sa_result_flat,
  input  logic                                           sa_computation_done,
  output logic                                           busy,
  output logic                                           cfg_error,
  output logic                                           timeout
);

  localparam int unsigned Cells  = ARRAY_SIZE * ARRAY_SIZE;
  localparam int unsigned AFlatW = DATA_WIDTH * Cells;
  localparam int unsigned BFlatW = WEIGHT_WIDTH * Cells;
  localparam int unsigned CFlatW = ACCUM_WIDTH * Cells;
  localparam int unsigned AIdxW  = $clog2(AFlatW);
  localparam int unsigned BIdxW  = $clog2(BFlatW);
  localparam int unsigned CIdxW  = $clog2(CFlatW);

  state_e              state_q, state_d;
  logic [DW-1:0]       m_q, m_d, n_q, n_d, k_q, k_d;
  logic [AFlatW-1:0]   a_flat_q, a_flat_d;
  logic [BFlatW-1:0]   b_flat_q, b_flat_d;
  logic [CFlatW-1:0]   res_q, res_d;
  logic cfg_ready_q, cfg_ready_d, a_ready_q, a_ready_d, b_ready_q, b_ready_d;
  logic sa_start_q, sa_start_d, r_valid_q, r_valid_d, busy_q, busy_d;
  logic cfg_error_q, cfg_error_d, timeout_q, timeout_d;

  logic cfg_hs, cfg_bad, cfg_accept, a_hs, b_hs, r_hs, wd_expired;

  assign cfg_hs     = cfg_valid && cfg_ready_q;
  assign cfg_bad    = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_inner == '0) ||
                      (cfg_rows > DW'(ARRAY_SIZE)) || (cfg_cols > DW'(ARRAY_SIZE)) ||
                      (cfg_inner > DW'(ARRAY_SIZE));
  assign cfg_accept = cfg_hs && !cfg_bad;
  assign a_hs       = a_valid && a_ready_q;
  assign b_hs       = b_valid && b_ready_q;
  assign r_hs       = r_valid_q && r_ready;

  logic [DW-1:0] a_row, a_col, b_row, b_col, d_row, d_col;
  logic          a_wrap, a_last, b_wrap, b_last, d_wrap, d_last;

  tile_rc_counter #(.W(DW)) u_a_cnt (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (cfg_accept),
    .step_i   (a_hs),
    .row_lim_i(m_q),
    .col_lim_i(k_q),
    .row_o    (a_row),
    .col_o    (a_col),
    .wrap_o   (a_wrap),
    .last_o   (a_last)
  );

  tile_rc_counter #(.W(DW)) u_b_cnt (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (cfg_accept),
    .step_i   (b_hs),
    .row_lim_i(k_q),
    .col_lim_i(n_q),
    .row_o    (b_row),
    .col_o    (b_col),
    .wrap_o   (b_wrap),
    .last_o   (b_last)
  );

  tile_rc_counter #(.W(DW)) u_d_cnt (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (cfg_accept),
    .step_i   (r_hs),
    .row_lim_i(m_q),
    .col_lim_i(n_q),
    .row_o    (d_row),
    .col_o    (d_col),
    .wrap_o   (d_wrap),
    .last_o   (d_last)
  );

  // Row-end flags are not needed here; only the final-element flags drive the FSM.
  logic unused_wrap;
  assign unused_wrap = a_wrap ^ b_wrap ^ d_wrap;

  logic [AIdxW-1:0] a_base;
  logic [BIdxW-1:0] b_base;
  logic [CIdxW-1:0] r_base;

  assign a_base = AIdxW'(idx(32'(a_row), 32'(a_col), ARRAY_SIZE) * DATA_WIDTH);
  assign b_base = BIdxW'(idx(32'(b_row), 32'(b_col), ARRAY_SIZE) * WEIGHT_WIDTH);
  assign r_base = CIdxW'(idx(32'(d_row), 32'(d_col), ARRAY_SIZE) * ACCUM_WIDTH);

`ifdef TILE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wd_q, wd_d;

  assign wd_expired = (wd_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d = '0;
    if (state_q == StWait) wd_d = wd_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    n_d         = n_q;
    k_d         = k_q;
    a_flat_d    = a_flat_q;
    b_flat_d    = b_flat_q;
    res_d       = res_q;
    cfg_error_d = 1'b0;
    timeout_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_hs) begin
          if (cfg_bad) begin
            cfg_error_d = 1'b1;
          end else begin
            m_d      = cfg_rows;
            n_d      = cfg_cols;
            k_d      = cfg_inner;
            a_flat_d = '0;
            b_flat_d = '0;
            state_d  = StLoadA;
          end
        end
      end
      StLoadA: begin
        if (a_hs) begin
          a_flat_d[a_base +: DATA_WIDTH] = a_data;
          if (a_last) state_d = StLoadB;
        end
      end
      StLoadB: begin
        if (b_hs) begin
          b_flat_d[b_base +: WEIGHT_WIDTH] = b_data;
          if (b_last) state_d = StStart;
        end
      end
      // done is deliberately not looked at in the start cycle.
      StStart: state_d = StWait;
      StWait: begin
        if (sa_computation_done) begin
          res_d   = sa_result_flat;
          state_d = StDrain;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StDrain: begin
        if (r_hs && d_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    cfg_ready_d = (state_d == StIdle);
    a_ready_d   = (state_d == StLoadA);
    b_ready_d   = (state_d == StLoadB);
    sa_start_d  = (state_d == StStart);
    r_valid_d   = (state_d == StDrain);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      a_flat_q    <= '0;
      b_flat_q    <= '0;
      res_q       <= '0;
      cfg_ready_q <= 1'b1;
      a_ready_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      sa_start_q  <= 1'b0;
      r_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      cfg_error_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      n_q         <= n_d;
      k_q         <= k_d;
      a_flat_q    <= a_flat_d;
      b_flat_q    <= b_flat_d;
      res_q       <= res_d;
      cfg_ready_q <= cfg_ready_d;
      a_ready_q   <= a_ready_d;
      b_ready_q   <= b_ready_d;
      sa_start_q  <= sa_start_d;
      r_valid_q   <= r_valid_d;
      busy_q      <= busy_d;
      cfg_error_q <= cfg_error_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cfg_ready        = cfg_ready_q;
  assign a_ready          = a_ready_q;
  assign b_ready          = b_ready_q;
  assign sa_start         = sa_start_q;
  assign r_valid          = r_valid_q;
  assign r_data           = res_q[r_base +: ACCUM_WIDTH];
  assign r_last           = r_valid_q && d_last;
  assign busy             = busy_q;
  assign cfg_error        = cfg_error_q;
  assign timeout          = timeout_q;
  assign sa_matrix_a_flat = a_flat_q;
  assign sa_matrix_b_flat = b_flat_q;

endmodule
